// File: rtl/gpr_regfile_pkg.sv
// Shared constants for the decode-stage general-purpose register file.
package gpr_regfile_pkg;

    localparam int unsigned XLEN_DEF    = 64;
    localparam int unsigned NR_REG_DEF  = 32;
    localparam int unsigned REG_SEL_DEF = 5;

    localparam logic [XLEN_DEF-1:0] RESET_VAL_DEF = 64'h0;

    // Architectural register indices
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/gpr_regfile_mux_key.sv
// Generic keyed lookup mux: returns the data of the pair whose key matches, else zero.
// Pair i sits at lut_i[i*(KEY_LEN+DATA_LEN) +: KEY_LEN+DATA_LEN] as {key, data}.
module mux_key #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                     key_i,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut_i,
    output logic [DATA_LEN-1:0]                    data_o
);

    localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (lut_i[i*PAIR_LEN + DATA_LEN +: KEY_LEN] == key_i) begin
                data_o = lut_i[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/gpr_regfile_reg_cell.sv
// Enable-gated register with asynchronous active-high reset to a fixed value.
module reg_cell #(
    parameter int unsigned       WIDTH     = 64,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/gpr_regfile.sv
// RV64 decode-stage register file: one synchronous write port, two combinational
// read ports, x0 hard-wired to zero, plus a flat debug snapshot of all registers.
module gpr_regfile
    import gpr_regfile_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEF,
    parameter int unsigned      NR_REG    = NR_REG_DEF,
    parameter int unsigned      REG_SEL   = REG_SEL_DEF,
    parameter logic [XLEN-1:0]  RESET_VAL = XLEN'(RESET_VAL_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [REG_SEL-1:0]     waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic [REG_SEL-1:0]     raddr1,
    input  logic [REG_SEL-1:0]     raddr2,
    output logic [XLEN-1:0]        rdata1,
    output logic [XLEN-1:0]        rdata2,
    output logic [NR_REG*XLEN-1:0] gpr_dbg
);

    localparam int unsigned PAIR_LEN = REG_SEL + NR_REG;

    logic [NR_REG*PAIR_LEN-1:0]    dec_lut;
    logic [NR_REG-1:0]             wr_onehot;
    logic [NR_REG-1:0][XLEN-1:0]   regs;

    // Decode table: key k -> (1<<k); key 0 maps to no enable so x0 is never written
    for (genvar k = 0; k < NR_REG; k++) begin : g_lut
        localparam logic [NR_REG-1:0] ENC = (k == 0) ? NR_REG'(0) : (NR_REG'(1) << k);
        assign dec_lut[k*PAIR_LEN +: PAIR_LEN] = {REG_SEL'(k), ENC};
    end

    mux_key #(
        .NR_KEY   (NR_REG),
        .KEY_LEN  (REG_SEL),
        .DATA_LEN (NR_REG)
    ) u_wr_dec (
        .key_i  (waddr),
        .lut_i  (dec_lut),
        .data_o (wr_onehot)
    );

    for (genvar i = 0; i < NR_REG; i++) begin : g_reg
        reg_cell #(
            .WIDTH     (XLEN),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en_i (wen & wr_onehot[i]),
            .d_i  (wdata),
            .q_o  (regs[i])
        );
    end

    // No write-through bypass: a same-cycle read sees the pre-edge value
    assign rdata1 = (raddr1 == REG_SEL'(REG_ZERO)) ? RESET_VAL : regs[raddr1];
    assign rdata2 = (raddr2 == REG_SEL'(REG_ZERO)) ? RESET_VAL : regs[raddr2];

    assign gpr_dbg = regs;

endmodule

// File: tb/tb_gpr_regfile.sv
// Self-checking bench for gpr_regfile: array model checked every negedge plus directed literal checks.
module tb_gpr_regfile;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned NR_REG  = 32;
    localparam int unsigned REG_SEL = 5;

    logic                   clk;
    logic                   rst;
    logic                   wen;
    logic [REG_SEL-1:0]     waddr;
    logic [XLEN-1:0]        wdata;
    logic [REG_SEL-1:0]     raddr1;
    logic [REG_SEL-1:0]     raddr2;
    logic [XLEN-1:0]        rdata1;
    logic [XLEN-1:0]        rdata2;
    logic [NR_REG*XLEN-1:0] gpr_dbg;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] model [NR_REG] = '{default: '0};

    gpr_regfile u_dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .gpr_dbg (gpr_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] dbg_slice(input int i);
        return gpr_dbg[i*XLEN +: XLEN];
    endfunction

    // Architectural model: reset clears everything, x0 ignores writes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) model[i] = '0;
        end else if (wen === 1'b1 && waddr != 0) begin
            model[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        chk("cyc_rdata1", rdata1, model[raddr1]);
        chk("cyc_rdata2", rdata2, model[raddr2]);
        for (int i = 0; i < NR_REG; i++) begin
            chk($sformatf("cyc_dbg[%0d]", i), dbg_slice(i), model[i]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_rdata1", rdata1, 64'h0);
        chk("reset_dbg31", dbg_slice(31), 64'h0);

        // basic write / read
        wen = 1'b1; waddr = 5'd5; wdata = 64'hDEAD_BEEF_0123_4567; raddr1 = 5'd5;
        step();
        wen = 1'b0;
        chk("wr5_rdata1", rdata1, 64'hDEAD_BEEF_0123_4567);
        chk("wr5_dbg4", dbg_slice(4), 64'h0);
        chk("wr5_dbg6", dbg_slice(6), 64'h0);

        // x0 protection
        wen = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        step();
        wen = 1'b0;
        chk("x0_rdata1", rdata1, 64'h0);
        chk("x0_rdata2", rdata2, 64'h0);
        chk("x0_dbg0", dbg_slice(0), 64'h0);

        // wen gating
        wen = 1'b0; waddr = 5'd7; wdata = 64'h1234; raddr1 = 5'd7;
        repeat (3) step();
        chk("gate_rdata1", rdata1, 64'h0);

        // unknown write index with wen low
        waddr = 'x;
        repeat (2) step();
        waddr = '0;
        chk("xaddr_dbg5", dbg_slice(5), 64'hDEAD_BEEF_0123_4567);

        // read during write: old value before the edge, new after
        wen = 1'b1; waddr = 5'd3; wdata = 64'h11;
        step();
        wdata = 64'h22; raddr2 = 5'd3;
        #1 chk("rdw_before", rdata2, 64'h11);
        step();
        wen = 1'b0;
        chk("rdw_after", rdata2, 64'h22);

        // sweep x1..x31
        for (int i = 1; i < NR_REG; i++) begin
            wen = 1'b1; waddr = REG_SEL'(i); wdata = 64'(i) * 64'h0101;
            step();
        end
        wen = 1'b0;
        for (int i = 0; i < NR_REG; i++) begin
            raddr1 = REG_SEL'(i); raddr2 = REG_SEL'(i);
            #1;
            chk($sformatf("sweep_p1[%0d]", i), rdata1, 64'(i) * 64'h0101);
            chk($sformatf("sweep_p2[%0d]", i), rdata2, 64'(i) * 64'h0101);
        end
        raddr1 = 5'd31; raddr2 = 5'd17;
        step();

        // async reset mid-cycle, no clock edge in between
        rst = 1'b1;
        #1;
        chk("arst_rdata1", rdata1, 64'h0);
        chk("arst_rdata2", rdata2, 64'h0);
        for (int i = 0; i < NR_REG; i++) begin
            chk($sformatf("arst_dbg[%0d]", i), dbg_slice(i), 64'h0);
        end

        // reset dominates a concurrent write
        wen = 1'b1; waddr = 5'd9; wdata = 64'h99; raddr1 = 5'd9;
        step();
        chk("rst_wr_dbg9", dbg_slice(9), 64'h0);
        rst = 1'b0; wen = 1'b0;
        step();
        chk("post_rst_rdata1", rdata1, 64'h0);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded budget", $time);
        $fatal(1);
    end

endmodule
